// File: rtl/wb_port_if.sv
// Bundles the write-back-to-register-file write-port signals of wb_port_scheduler.
// The master modport is the write-back/pipeline side; the slave modport is the scheduler.
interface wb_port_if #(
  parameter int DEPTH = 4
);
  // Handshake: the scheduler takes wr1/wr2 on a rising edge only when stall == 0
  // and flush == 0 in that cycle. While stall == 1, upstream holds its requests
  // unchanged. stall depends only on the queue occupancy, never on wr1/wr2.
  logic                      flush;
  logic                      wr1;
  logic [3:0]                wr_reg1;
  logic [15:0]               wr_data1;
  logic                      wr2;
  logic [3:0]                wr_reg2;
  logic [15:0]               wr_data2;
  logic                      stall;
  logic                      rf_we;
  logic [3:0]                rf_waddr;
  logic [15:0]               rf_wdata;
  logic [$clog2(DEPTH):0]    pending;
  logic [3:0]                lookup_reg;
  logic                      lookup_hit;
  logic [15:0]               lookup_data;
  logic [0:0]                dbg_state;

  modport master (
    output flush, wr1, wr_reg1, wr_data1, wr2, wr_reg2, wr_data2, lookup_reg,
    input  stall, rf_we, rf_waddr, rf_wdata, pending, lookup_hit, lookup_data, dbg_state
  );

  modport slave (
    input  flush, wr1, wr_reg1, wr_data1, wr2, wr_reg2, wr_data2, lookup_reg,
    output stall, rf_we, rf_waddr, rf_wdata, pending, lookup_hit, lookup_data, dbg_state
  );
endinterface

// File: rtl/wb_port_scheduler.sv
// Serialises up to two write-back register writes per cycle onto one register-file port
// through an in-order queue. Optional feature macro: WB_BYPASS_EN (pending-write forwarding).
module wb_port_scheduler #(
  parameter int DEPTH = 4
) (
  input logic     clk,
  input logic     reset,
  wb_port_if.slave wb
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_BUSY = 1'b1;

  logic [3:0]    reg_q  [DEPTH];
  logic [15:0]   data_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [PW-1:0] pending_q;
  logic          rf_we_q;
  logic [3:0]    rf_waddr_q;
  logic [15:0]   rf_wdata_q;

  logic          accept, take1, take2, pop;
  logic [1:0]    n_acc, n_push;
  logic [3:0]    e0_reg, e1_reg, p0_reg, p1_reg;
  logic [15:0]   e0_data, e1_data, p0_data, p1_data;

  // Room for a full dual write must exist before anything is accepted.
  assign wb.stall = (pending_q > PW'(DEPTH - 2));

  always_comb begin
    accept = ~wb.stall & ~wb.flush;
    take1  = accept & wb.wr1;
    // Slot 1 supersedes slot 2 on the same register, so slot 2 is dropped.
    take2  = accept & wb.wr2 & ~(wb.wr1 & (wb.wr_reg1 == wb.wr_reg2));
    n_acc  = {1'b0, take1} + {1'b0, take2};
    if (take2) begin
      e0_reg = wb.wr_reg2; e0_data = wb.wr_data2;
    end else begin
      e0_reg = wb.wr_reg1; e0_data = wb.wr_data1;
    end
    e1_reg = wb.wr_reg1; e1_data = wb.wr_data1;
    pop    = (pending_q != '0);
    if (pop) begin
      p0_reg = e0_reg; p0_data = e0_data;
      p1_reg = e1_reg; p1_data = e1_data;
      n_push = n_acc;
    end else begin
      // Empty queue: the first accepted write bypasses the queue straight to rf_*.
      p0_reg = e1_reg; p0_data = e1_data;
      p1_reg = e1_reg; p1_data = e1_data;
      n_push = (n_acc == 2'd2) ? 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!wb.flush) begin
      if (n_push != 2'd0) begin
        reg_q[tail_q]  <= p0_reg;
        data_q[tail_q] <= p0_data;
      end
      if (n_push == 2'd2) begin
        reg_q[tail_q + AW'(1)]  <= p1_reg;
        data_q[tail_q + AW'(1)] <= p1_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      pending_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (wb.flush) begin
      head_q    <= '0;
      tail_q    <= '0;
      pending_q <= '0;
      rf_we_q   <= 1'b0;
    end else begin
      if (pop) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= reg_q[head_q];
        rf_wdata_q <= data_q[head_q];
        head_q     <= head_q + AW'(1);
      end else if (n_acc != 2'd0) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= e0_reg;
        rf_wdata_q <= e0_data;
      end else begin
        rf_we_q <= 1'b0;
      end
      tail_q    <= tail_q + AW'(n_push);
      pending_q <= pending_q + PW'(n_push) - PW'(pop);
    end
  end

  assign wb.rf_we     = rf_we_q;
  assign wb.rf_waddr  = rf_waddr_q;
  assign wb.rf_wdata  = rf_wdata_q;
  assign wb.pending   = pending_q;
  assign wb.dbg_state = (pending_q == '0) ? STATE_IDLE : STATE_BUSY;

`ifdef WB_BYPASS_EN
  logic [AW-1:0] idx;
  logic          hit;
  logic [15:0]   hit_data;

  // Oldest to newest, so a later (newer) match overrides an earlier one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    if (rf_we_q && (rf_waddr_q == wb.lookup_reg)) begin
      hit      = 1'b1;
      hit_data = rf_wdata_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if ((PW'(i) < pending_q) && (reg_q[idx] == wb.lookup_reg)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  assign wb.lookup_hit  = hit;
  assign wb.lookup_data = hit_data;
`else
  assign wb.lookup_hit  = 1'b0;
  assign wb.lookup_data = '0;
`endif
endmodule
